rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Arbitrates one combinational, word-indexed instruction ROM between two requesters: port 0 = instruction fetch, port 1 = data/debug read (e.g. lw from the code region, loader readback).
- Registers the ROM output, so every response arrives one cycle after acceptance.
- Uses round-robin grant, with valid/ready handshakes on both request and response channels.
- Sits between the core's PC/LSU logic and the ROM.

Parameters:
- DEPTH, 16, number of 32-bit words in the ROM; word index = addr[31:2].
- IDX_W, $clog2(DEPTH), width of the in-range index check.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  2  per-port request valid; bit 0 = fetch, bit 1 = data
- req_addr0  input  32  port 0 byte address
- req_addr1  input  32  port 1 byte address
- req_ready  output  2  per-port request accepted this cycle when valid&ready
- rsp_valid  output  2  per-port response valid
- rsp_ready  input  2  per-port response consumed when valid&ready
- rsp_data0  output  32  port 0 read data
- rsp_data1  output  32  port 1 read data
- rsp_err  output  2  per-port error flag, qualified by rsp_valid; only with feature
- mem_addr  output  32  byte address driven to ROM
- mem_data  input  32  ROM combinational read data

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, on port reset.
- Reset values: rsp_valid=0, rsp_data0/1=0, rsp_err=0, last_grant=1 (port 0 wins first tie), mem_addr=0.
- Per-port response slot is one entry deep; each port has at most one outstanding access.
- slot_free[i] = !rsp_valid[i] || rsp_ready[i]. The same-cycle drain-and-refill allows 1 access/cycle/port throughput.
- Eligibility: eligible[i] = req_valid[i] && slot_free[i].
- Grant:
  - If only one port is eligible, it wins.
  - If both are eligible, the port != last_grant wins.
  - last_grant updates only on a grant.
- Handshake: req_ready[i] = 1 only for the granted port, combinational from the current inputs.
- The requester must hold req_addr stable while valid && !ready.
- mem_addr is combinational: the granted port's address, else port 0's address (don't-care).
- Data capture: on a grant to port i, at the next edge, rsp_data_i <= mem_data and rsp_valid[i] <= 1.
  - Out-of-range access (addr[31:2] >= DEPTH) captures 32'h0000_0000 instead of mem_data.
- Response hold: rsp_valid[i] and rsp_data_i stay stable until rsp_ready[i]. On consumption with no new grant, rsp_valid[i] <= 0 and data holds its last value.
- Latency: exactly 1 cycle from accept to rsp_valid with no contention. The loser of a tie waits 1 extra cycle.
- Starvation: with both ports continuously eligible, grants strictly alternate 0,1,0,1.
- A blocked port (rsp_valid=1, rsp_ready=0) never receives a grant. The other port may take every cycle.
- Mid-operation reset: any accepted-but-unreturned access is dropped. No response appears after reset. last_grant returns to 1.
- FSM per port: EMPTY (rsp_valid=0) -> FULL on grant; FULL -> EMPTY on rsp_ready without grant; FULL -> FULL on rsp_ready with grant (new data).

Optional Feature:
- Macro: ROM_ARB_ALIGN_CHK_EN.
- Enabled:
  - A granted request with addr[1:0] != 0 is still accepted (req_ready=1) but is not looked up.
  - Next cycle: rsp_valid=1, rsp_err[i]=1, rsp_data_i=0.
  - rsp_err[i] clears on the next non-error capture or on reset.
  - Out-of-range addresses also set rsp_err.
- Disabled:
  - addr[1:0] is ignored; the ROM reads addr[31:2].
  - rsp_err is tied to 0.

Test Plan:
- Reset for 2 cycles with req_valid=2'b11 -> req_ready=0 and rsp_valid=0 throughout reset; first grant after release goes to port 0.
- Memory model word0=0x00110233. Port 0 only, addr 0x0, rsp_ready=1 -> req_ready0=1 at cycle t; rsp_valid0=1 and rsp_data0=0x00110233 at t+1.
- Both ports continuously valid (addr0=0x4, addr1=0x8), both rsp_ready=1 -> grants alternate 0,1,0,1 over 8 cycles; each port receives 4 responses.
- Port 1 rsp_ready=0 for 5 cycles after its first response -> port 1 is not granted, rsp_data1 is stable, port 0 is granted every cycle; on release, port 1 is granted the same cycle.
- Port 0 addr 0x40 (index 16, DEPTH=16) -> rsp_data0=0x00000000. With ROM_ARB_ALIGN_CHK_EN: rsp_err0=1; port 1 addr 0x6 -> rsp_err1=1, rsp_data1=0.
- Reset asserted the cycle after port 1 is accepted -> no rsp_valid1 after reset deasserts.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// Request/response handshake bundle between the two ROM requesters and rom_arbiter.
// Bit 0 of each 2-bit vector is the fetch port, bit 1 is the data/debug port.
interface rom_arbiter_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_addr0;
   logic [31:0] req_addr1;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_data0;
   logic [31:0] rsp_data1;
   logic [1:0]  rsp_err;

   modport slave (
      input  req_valid, req_addr0, req_addr1, rsp_ready,
      output req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_err
   );

   modport master (
      output req_valid, req_addr0, req_addr1, rsp_ready,
      input  req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_err
   );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one combinational word ROM between fetch (port 0) and data (port 1).
// Optional ROM_ARB_ALIGN_CHK_EN: misaligned/out-of-range accesses return zero data with rsp_err set.
//
// state   | meaning (one slot per port)
// S_EMPTY | no response held, rsp_valid=0
// S_FULL  | response held in rsp_data, rsp_valid=1 until rsp_ready
module rom_arbiter #(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   rom_arbiter_if.slave  bus,
   output logic [31:0]   mem_addr,
   input  logic [31:0]   mem_data
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } slot_state_e;

   localparam logic [IDX_W:0] DEPTH_L = DEPTH[IDX_W:0];

   slot_state_e state_q [2];
   slot_state_e state_d [2];
   logic [31:0] data_q [2];
   logic [31:0] data_d [2];
   logic        last_grant_q;
   logic        last_grant_d;

   logic [1:0]  rsp_valid;
   logic [1:0]  slot_free;
   logic [1:0]  eligible;
   logic [1:0]  grant;
   logic [31:0] gnt_addr;
   logic        in_range;
   logic        lookup_ok;
   logic [31:0] cap_data;

`ifdef ROM_ARB_ALIGN_CHK_EN
   logic [1:0]  err_q;
   logic [1:0]  err_d;
`endif

   assign rsp_valid = {state_q[1] == S_FULL, state_q[0] == S_FULL};
   assign slot_free = ~rsp_valid | bus.rsp_ready;
   assign eligible  = bus.req_valid & slot_free;

   // On a tie the port that did not win last time goes first.
   always_comb begin
      grant = 2'b00;
      if (!reset) begin
         if (eligible == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
         end else begin
            grant = eligible;
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (grant[1]) begin
         last_grant_d = 1'b1;
      end else if (grant[0]) begin
         last_grant_d = 1'b0;
      end
   end

   assign gnt_addr = grant[1] ? bus.req_addr1 : bus.req_addr0;
   assign mem_addr = reset ? 32'h0000_0000 : gnt_addr;

   assign in_range = (gnt_addr[31:IDX_W+2] == '0) &&
                     ({1'b0, gnt_addr[IDX_W+1:2]} < DEPTH_L);

`ifdef ROM_ARB_ALIGN_CHK_EN
   assign lookup_ok = in_range && (gnt_addr[1:0] == 2'b00);
`else
   assign lookup_ok = in_range;
`endif

   assign cap_data = lookup_ok ? mem_data : 32'h0000_0000;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_d[i] = state_q[i];
         data_d[i]  = data_q[i];
`ifdef ROM_ARB_ALIGN_CHK_EN
         err_d[i]   = err_q[i];
`endif
         if (grant[i]) begin
            state_d[i] = S_FULL;
            data_d[i]  = cap_data;
`ifdef ROM_ARB_ALIGN_CHK_EN
            err_d[i]   = !lookup_ok;
`endif
         end else if (state_q[i] == S_FULL && bus.rsp_ready[i]) begin
            state_d[i] = S_EMPTY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q[0]   <= S_EMPTY;
         state_q[1]   <= S_EMPTY;
         data_q[0]    <= 32'h0000_0000;
         data_q[1]    <= 32'h0000_0000;
         last_grant_q <= 1'b1;
`ifdef ROM_ARB_ALIGN_CHK_EN
         err_q        <= 2'b00;
`endif
      end else begin
         state_q[0]   <= state_d[0];
         state_q[1]   <= state_d[1];
         data_q[0]    <= data_d[0];
         data_q[1]    <= data_d[1];
         last_grant_q <= last_grant_d;
`ifdef ROM_ARB_ALIGN_CHK_EN
         err_q        <= err_d;
`endif
      end
   end

   assign bus.req_ready = grant;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data0 = data_q[0];
   assign bus.rsp_data1 = data_q[1];

`ifdef ROM_ARB_ALIGN_CHK_EN
   assign bus.rsp_err = err_q;
`else
   assign bus.rsp_err = 2'b00;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed, table-driven bench for rom_arbiter plus hand sequences for reset corner cases.
module tb_rom_arbiter;

`ifdef ROM_ARB_ALIGN_CHK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   localparam logic [31:0] W0 = 32'h0011_0233;
   localparam logic [31:0] W1 = 32'hC0DE_0001;
   localparam logic [31:0] W2 = 32'hC0DE_0002;
   localparam logic [31:0] W3 = 32'hC0DE_0003;

   logic        clk;
   logic        reset;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;

   rom_arbiter_if bus ();

   rom_arbiter #(.DEPTH(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .mem_addr (mem_addr),
      .mem_data (mem_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM model: word 0 fixed, others tagged with their index; index wraps past 16
   always_comb begin
      if (mem_addr[5:2] == 4'd0) mem_data = W0;
      else                       mem_data = 32'hC0DE_0000 | {28'h0, mem_addr[5:2]};
   end

   typedef struct {
      logic [1:0]  rv;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [1:0]  rr;
      logic [1:0]  e_rdy;
      logic [1:0]  e_vld;
      logic [31:0] e_d0;
      logic [31:0] e_d1;
      logic [1:0]  e_err;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(logic [1:0] rv, logic [31:0] a0, logic [31:0] a1, logic [1:0] rr,
                               logic [1:0] e_rdy, logic [1:0] e_vld, logic [31:0] e_d0,
                               logic [31:0] e_d1, logic [1:0] e_err);
      vec_t v;
      v.rv = rv; v.a0 = a0; v.a1 = a1; v.rr = rr;
      v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_err = e_err;
      return v;
   endfunction

   function automatic logic [1:0] en(logic [1:0] x);
      return ERR_EN ? x : 2'b00;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(logic [1:0] rv, logic [31:0] a0, logic [31:0] a1, logic [1:0] rr);
      bus.req_valid = rv;
      bus.req_addr0 = a0;
      bus.req_addr1 = a1;
      bus.rsp_ready = rr;
   endtask

   logic [31:0] d6;

   initial begin
      d6 = ERR_EN ? 32'h0 : W1;
      // Each row: inputs applied for one cycle; expectations are the outputs seen during that cycle
      vecs.push_back(mk(2'b11, 32'h0,  32'h8, 2'b11, 2'b01, 2'b00, 32'h0, 32'h0, 2'b00)); // 0 first tie -> port 0
      vecs.push_back(mk(2'b01, 32'h0,  32'h8, 2'b11, 2'b01, 2'b01, W0,    32'h0, 2'b00)); // 1
      vecs.push_back(mk(2'b00, 32'h0,  32'h8, 2'b11, 2'b00, 2'b01, W0,    32'h0, 2'b00)); // 2
      vecs.push_back(mk(2'b00, 32'h0,  32'h8, 2'b11, 2'b00, 2'b00, W0,    32'h0, 2'b00)); // 3
      vecs.push_back(mk(2'b11, 32'h4,  32'h8, 2'b11, 2'b10, 2'b00, W0,    32'h0, 2'b00)); // 4 alternation
      vecs.push_back(mk(2'b11, 32'h4,  32'h8, 2'b11, 2'b01, 2'b10, W0,    W2,    2'b00)); // 5
      vecs.push_back(mk(2'b11, 32'h4,  32'h8, 2'b11, 2'b10, 2'b01, W1,    W2,    2'b00)); // 6
      vecs.push_back(mk(2'b11, 32'h4,  32'h8, 2'b11, 2'b01, 2'b10, W1,    W2,    2'b00)); // 7
      vecs.push_back(mk(2'b11, 32'h4,  32'h8, 2'b11, 2'b10, 2'b01, W1,    W2,    2'b00)); // 8
      vecs.push_back(mk(2'b11, 32'h4,  32'h8, 2'b11, 2'b01, 2'b10, W1,    W2,    2'b00)); // 9
      vecs.push_back(mk(2'b11, 32'h4,  32'h8, 2'b11, 2'b10, 2'b01, W1,    W2,    2'b00)); // 10
      vecs.push_back(mk(2'b11, 32'h4,  32'h8, 2'b11, 2'b01, 2'b10, W1,    W2,    2'b00)); // 11
      vecs.push_back(mk(2'b00, 32'h4,  32'h8, 2'b11, 2'b00, 2'b01, W1,    W2,    2'b00)); // 12
      vecs.push_back(mk(2'b00, 32'h4,  32'h8, 2'b11, 2'b00, 2'b00, W1,    W2,    2'b00)); // 13
      vecs.push_back(mk(2'b01, 32'h40, 32'h8, 2'b11, 2'b01, 2'b00, W1,    W2,    2'b00)); // 14 out of range
      vecs.push_back(mk(2'b00, 32'h40, 32'h8, 2'b11, 2'b00, 2'b01, 32'h0, W2,    en(2'b01))); // 15
      vecs.push_back(mk(2'b10, 32'h40, 32'h6, 2'b11, 2'b10, 2'b00, 32'h0, W2,    en(2'b01))); // 16 misaligned
      vecs.push_back(mk(2'b00, 32'h40, 32'h6, 2'b11, 2'b00, 2'b10, 32'h0, d6,    en(2'b11))); // 17
      vecs.push_back(mk(2'b10, 32'h40, 32'h8, 2'b11, 2'b10, 2'b00, 32'h0, d6,    en(2'b11))); // 18
      vecs.push_back(mk(2'b00, 32'h40, 32'h8, 2'b11, 2'b00, 2'b10, 32'h0, W2,    en(2'b01))); // 19 err1 clears
      vecs.push_back(mk(2'b01, 32'h4,  32'h8, 2'b11, 2'b01, 2'b00, 32'h0, W2,    en(2'b01))); // 20
      vecs.push_back(mk(2'b00, 32'h4,  32'h8, 2'b11, 2'b00, 2'b01, W1,    W2,    2'b00)); // 21 err0 clears
      vecs.push_back(mk(2'b10, 32'h4,  32'hC, 2'b11, 2'b10, 2'b00, W1,    W2,    2'b00)); // 22
      vecs.push_back(mk(2'b11, 32'h0,  32'hC, 2'b01, 2'b01, 2'b10, W1,    W3,    2'b00)); // 23 port 1 blocked
      vecs.push_back(mk(2'b11, 32'h0,  32'hC, 2'b01, 2'b01, 2'b11, W0,    W3,    2'b00)); // 24
      vecs.push_back(mk(2'b11, 32'h0,  32'hC, 2'b01, 2'b01, 2'b11, W0,    W3,    2'b00)); // 25
      vecs.push_back(mk(2'b11, 32'h0,  32'hC, 2'b01, 2'b01, 2'b11, W0,    W3,    2'b00)); // 26
      vecs.push_back(mk(2'b11, 32'h0,  32'hC, 2'b01, 2'b01, 2'b11, W0,    W3,    2'b00)); // 27
      vecs.push_back(mk(2'b11, 32'h0,  32'h8, 2'b11, 2'b10, 2'b11, W0,    W3,    2'b00)); // 28 release
      vecs.push_back(mk(2'b00, 32'h0,  32'h8, 2'b11, 2'b00, 2'b10, W0,    W2,    2'b00)); // 29
      vecs.push_back(mk(2'b00, 32'h0,  32'h8, 2'b11, 2'b00, 2'b00, W0,    W2,    2'b00)); // 30

      reset = 1'b1;
      drive(2'b11, 32'h0, 32'h8, 2'b11);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); #1;
         chk($sformatf("reset%0d req_ready", c), {30'h0, bus.req_ready}, 32'h0);
         chk($sformatf("reset%0d rsp_valid", c), {30'h0, bus.rsp_valid}, 32'h0);
      end
      reset = 1'b0;
      drive(2'b00, 32'h0, 32'h8, 2'b11);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].rv, vecs[i].a0, vecs[i].a1, vecs[i].rr);
         #1;
         chk($sformatf("row%0d req_ready", i), {30'h0, bus.req_ready}, {30'h0, vecs[i].e_rdy});
         chk($sformatf("row%0d rsp_valid", i), {30'h0, bus.rsp_valid}, {30'h0, vecs[i].e_vld});
         chk($sformatf("row%0d rsp_data0", i), bus.rsp_data0, vecs[i].e_d0);
         chk($sformatf("row%0d rsp_data1", i), bus.rsp_data1, vecs[i].e_d1);
         chk($sformatf("row%0d rsp_err", i),   {30'h0, bus.rsp_err},   {30'h0, vecs[i].e_err});
      end

      // Reset right after port 1 is accepted: the response must not survive it
      @(negedge clk);
      drive(2'b10, 32'h0, 32'h4, 2'b11);
      #1 chk("midrst accept", {30'h0, bus.req_ready}, 32'h2);
      @(negedge clk);
      reset = 1'b1;
      drive(2'b00, 32'h0, 32'h4, 2'b11);
      #1 chk("midrst rsp arrived", {30'h0, bus.rsp_valid}, 32'h2);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1 chk($sformatf("postrst%0d rsp_valid", c), {30'h0, bus.rsp_valid}, 32'h0);
         @(negedge clk);
      end

      // last_grant must return to 1 so port 0 wins the first tie after reset
      drive(2'b01, 32'h4, 32'h4, 2'b11);
      #1 chk("lg grant0", {30'h0, bus.req_ready}, 32'h1);
      @(negedge clk);
      reset = 1'b1;
      drive(2'b00, 32'h4, 32'h4, 2'b11);
      @(negedge clk);
      reset = 1'b0;
      drive(2'b11, 32'h4, 32'h8, 2'b11);
      #1 chk("lg tie after reset", {30'h0, bus.req_ready}, 32'h1);
      chk("lg rsp_valid after reset", {30'h0, bus.rsp_valid}, 32'h0);
      @(negedge clk);
      drive(2'b00, 32'h4, 32'h8, 2'b11);
      #1 chk("lg rsp data0", bus.rsp_data0, W1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
